// File: rtl/sd_sector_dma_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the SD sector DMA engine.
package sd_sector_dma_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

endpackage

// File: rtl/sd_sector_dma.sv
// AHB-Lite single-beat copy engine: read one word, write it back out, repeat,
// then pulse done. Moves SD sectors between the SD buffer window and RAM.
module sd_sector_dma
  import sd_sector_dma_pkg::*;
#(
  parameter int CNT_W    = 11,
  parameter int ADDR_INC = 4
) (
  input  logic             clkCPU,
  input  logic             globlRst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HBURST,
  output logic [2:0]       HSIZE,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  state_t           state, state_nx;
  logic [31:0]      src_r, dst_r, data_r;
  logic [CNT_W-1:0] cnt_r;
  logic             done_r, err_r;

  // Byte lanes below the word are dropped on latch; only word transfers exist.
  logic unused_lsbs;
  assign unused_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

  always_ff @(posedge clkCPU) begin
    if (globlRst) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = (word_cnt == '0) ? ST_FIN : ST_RD_A;
      ST_RD_A: if (HREADY) state_nx = ST_RD_D;
      ST_RD_D: if (HREADY) state_nx = (HRESP == HRESP_ERROR) ? ST_FIN : ST_WR_A;
      ST_WR_A: if (HREADY) state_nx = ST_WR_D;
      ST_WR_D: begin
        if (HREADY) begin
          if (HRESP == HRESP_ERROR)        state_nx = ST_FIN;
          else if (cnt_r == CNT_W'(1))     state_nx = ST_FIN;
          else                             state_nx = ST_RD_A;
        end
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Address phases are the only NONSEQ cycles; data phases always show IDLE.
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = 32'h0;
    HWRITE = 1'b0;
    case (state)
      ST_RD_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = src_r;
      end
      ST_WR_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = dst_r;
        HWRITE = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkCPU) begin
    if (globlRst) begin
      src_r  <= '0;
      dst_r  <= '0;
      cnt_r  <= '0;
      data_r <= '0;
      err_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == ST_FIN);
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_r <= {src_addr[31:2], 2'b00};
            dst_r <= {dst_addr[31:2], 2'b00};
            cnt_r <= word_cnt;
            err_r <= 1'b0;
          end
        end
        ST_RD_D: begin
          if (HREADY) begin
            data_r <= HRDATA;
            if (HRESP == HRESP_ERROR) err_r <= 1'b1;
          end
        end
        ST_WR_D: begin
          if (HREADY) begin
            if (HRESP == HRESP_ERROR) begin
              err_r <= 1'b1;
            end else begin
              src_r <= src_r + 32'(ADDR_INC);
              dst_r <= dst_r + 32'(ADDR_INC);
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != ST_IDLE);
  assign done   = done_r;
  assign err    = err_r;
  assign HWDATA = data_r;
  assign HBURST = HBURST_SINGLE;
  assign HSIZE  = HSIZE_WORD;

endmodule

// File: tb/tb_sd_sector_dma.sv
// Directed bench for sd_sector_dma: AHB slave model with stall/error injection,
// a vector table for whole jobs, and hand sequences for start/reset corners.
module tb_sd_sector_dma;
  localparam int CNT_W = 11;

  logic             clkCPU, globlRst, start;
  logic [31:0]      src_addr, dst_addr;
  logic [CNT_W-1:0] word_cnt;
  logic             busy, done, err;
  logic [31:0]      HADDR, HWDATA, HRDATA;
  logic [1:0]       HTRANS;
  logic [2:0]       HBURST, HSIZE;
  logic             HWRITE, HREADY, HRESP;

  sd_sector_dma #(.CNT_W(CNT_W), .ADDR_INC(4)) dut (
    .clkCPU(clkCPU), .globlRst(globlRst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  initial begin
    clkCPU = 1'b0;
    forever #5 clkCPU = ~clkCPU;
  end

  // ---- slave model: memory is written only by the stimulus process ----
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ra_log[$], wa_log[$], wd_log[$];
  int ra_base, wa_base, wd_base;
  int stall_rd, stall_cyc, err_wr;
  logic        dp_act, dp_wr, dp_err;
  logic [31:0] dp_addr, dp_rdata;
  int          dp_wait;

  always @(posedge clkCPU) begin
    if (globlRst) begin
      dp_act <= 1'b0; dp_wr <= 1'b0; dp_err <= 1'b0; dp_wait <= 0;
      dp_addr <= '0; dp_rdata <= '0;
    end else begin
      if (dp_act && HREADY) begin
        if (dp_wr && !HRESP) wd_log.push_back(HWDATA);
        dp_act <= 1'b0;
      end else if (dp_act) begin
        dp_wait <= dp_wait - 1;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        dp_act <= 1'b1; dp_wr <= HWRITE; dp_addr <= HADDR;
        dp_err <= 1'b0; dp_wait <= 0;
        if (HWRITE) begin
          wa_log.push_back(HADDR);
          if (wa_log.size() - wa_base == err_wr) dp_err <= 1'b1;
        end else begin
          ra_log.push_back(HADDR);
          if (ra_log.size() - ra_base == stall_rd) dp_wait <= stall_cyc;
          dp_rdata <= mem.exists(HADDR) ? mem[HADDR] : 32'hDEADBEEF;
        end
      end
    end
  end

  assign HREADY = !(dp_act && dp_wait != 0);
  assign HRESP  = dp_act && dp_err && HREADY;
  assign HRDATA = (dp_act && !dp_wr && HREADY) ? dp_rdata : 32'hBAD0BAD0;

  // Protocol monitor: back-to-back NONSEQ, NONSEQ in a data phase, constants.
  logic prev_acc = 1'b0;
  int   viol = 0;
  always @(negedge clkCPU) begin
    if (prev_acc && HTRANS == 2'b10) viol++;
    if (dp_act && HTRANS != 2'b00) viol++;
    if (HBURST != 3'b000 || HSIZE != 3'b010) viol++;
    if (HTRANS != 2'b00 && HTRANS != 2'b10) viol++;
    prev_acc = (HTRANS == 2'b10) && HREADY;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int v, input int i);
    return (32'h11111111 * (i + 1)) ^ (32'(v) << 4);
  endfunction

  // Called just after the start edge (cyc already counted); returns the cycle
  // index of the done pulse, or the bound if it never came.
  task automatic wait_done(input int c0, output int cyc, output int bcyc);
    cyc = c0; bcyc = 0;
    while (!done && cyc < 300) begin
      if (busy) bcyc++;
      @(posedge clkCPU); #1;
      cyc++;
    end
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                         output int cyc, output int bcyc);
    @(negedge clkCPU);
    src_addr = s; dst_addr = d; word_cnt = CNT_W'(n); start = 1'b1;
    @(posedge clkCPU); #1;
    start = 1'b0;
    wait_done(1, cyc, bcyc);
  endtask

  task automatic mark_bases;
    ra_base = ra_log.size(); wa_base = wa_log.size(); wd_base = wd_log.size();
  endtask

  typedef struct {
    logic [31:0] src, dst, src0, dst0;
    int cnt, stall_rd, stall_cyc, err_wr, exp_cyc;
    logic exp_err;
    int exp_rd, exp_wa, exp_ok;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, bcyc, pulses;
    logic [31:0] a;
    globlRst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_cnt = '0;
    stall_rd = 0; stall_cyc = 0; err_wr = 0;
    ra_base = 0; wa_base = 0; wd_base = 0;

    vecs[0] = '{32'h1FC00000, 32'h00001000, 32'h1FC00000, 32'h00001000, 4, 0, 0, 0, 18, 1'b0, 4, 4, 4};
    vecs[1] = '{32'h1FC00000, 32'h00001000, 32'h1FC00000, 32'h00001000, 0, 0, 0, 0,  2, 1'b0, 0, 0, 0};
    vecs[2] = '{32'h1FC00040, 32'h00003000, 32'h1FC00040, 32'h00003000, 2, 2, 3, 0, 13, 1'b0, 2, 2, 2};
    vecs[3] = '{32'h1FC00080, 32'h00004000, 32'h1FC00080, 32'h00004000, 4, 0, 0, 2, 10, 1'b1, 2, 2, 1};
    vecs[4] = '{32'h1FC00003, 32'h00002002, 32'h1FC00000, 32'h00002000, 2, 0, 0, 0, 10, 1'b0, 2, 2, 2};
    vecs[5] = '{32'hFFFFFFFC, 32'h00005000, 32'hFFFFFFFC, 32'h00005000, 2, 0, 0, 0, 10, 1'b0, 2, 2, 2};

    repeat (3) @(posedge clkCPU);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_htrans", 32'(HTRANS), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", 32'(HWRITE), 0);
    chk("rst_hwdata", HWDATA, 0);
    @(negedge clkCPU) globlRst = 1'b0;
    repeat (2) @(posedge clkCPU);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].cnt; i++) begin
        a = vecs[v].src0 + 32'(4 * i);
        mem[a] = pat(v, i);
      end
      stall_rd = vecs[v].stall_rd; stall_cyc = vecs[v].stall_cyc; err_wr = vecs[v].err_wr;
      mark_bases();
      run_job(vecs[v].src, vecs[v].dst, vecs[v].cnt, cyc, bcyc);
      chk($sformatf("v%0d_done_cycle", v), 32'(cyc), 32'(vecs[v].exp_cyc));
      chk($sformatf("v%0d_busy_cycles", v), 32'(bcyc), 32'(vecs[v].exp_cyc - 1));
      chk($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_nreads", v), 32'(ra_log.size() - ra_base), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d_nwaddr", v), 32'(wa_log.size() - wa_base), 32'(vecs[v].exp_wa));
      chk($sformatf("v%0d_nwdata", v), 32'(wd_log.size() - wd_base), 32'(vecs[v].exp_ok));
      for (int i = 0; i < vecs[v].exp_rd && ra_base + i < ra_log.size(); i++)
        chk($sformatf("v%0d_raddr%0d", v, i), ra_log[ra_base + i], vecs[v].src0 + 32'(4 * i));
      for (int i = 0; i < vecs[v].exp_wa && wa_base + i < wa_log.size(); i++)
        chk($sformatf("v%0d_waddr%0d", v, i), wa_log[wa_base + i], vecs[v].dst0 + 32'(4 * i));
      for (int i = 0; i < vecs[v].exp_ok && wd_base + i < wd_log.size(); i++)
        chk($sformatf("v%0d_wdata%0d", v, i), wd_log[wd_base + i], pat(v, i));
      @(posedge clkCPU); #1;
      chk($sformatf("v%0d_done_one_cycle", v), 32'(done), 0);
      chk($sformatf("v%0d_idle_busy", v), 32'(busy), 0);
      chk($sformatf("v%0d_idle_htrans", v), 32'(HTRANS), 0);
    end

    // err stays set while idle, then clears on the next accepted start
    stall_rd = 0; err_wr = 1; mark_bases();
    mem[32'h1FC00200] = 32'hCAFE0001;
    run_job(32'h1FC00200, 32'h00006000, 2, cyc, bcyc);
    chk("errjob_done_cycle", 32'(cyc), 6);
    repeat (3) @(posedge clkCPU);
    #1;
    chk("err_sticky", 32'(err), 1);
    err_wr = 0;
    @(negedge clkCPU);
    src_addr = 32'h1FC00200; dst_addr = 32'h00006100; word_cnt = CNT_W'(1); start = 1'b1;
    @(posedge clkCPU); #1;
    start = 1'b0;
    chk("err_cleared_on_start", 32'(err), 0);
    chk("busy_after_start", 32'(busy), 1);
    wait_done(1, cyc, bcyc);
    chk("clearjob_done_cycle", 32'(cyc), 6);

    // start while busy is ignored; the latched job runs unchanged
    mem[32'h1FC00300] = 32'hA5A50000; mem[32'h1FC00304] = 32'hA5A50001;
    mark_bases();
    @(negedge clkCPU);
    src_addr = 32'h1FC00300; dst_addr = 32'h00007000; word_cnt = CNT_W'(2); start = 1'b1;
    @(posedge clkCPU); #1;
    start = 1'b0; cyc = 1;
    repeat (2) begin @(posedge clkCPU); #1; cyc++; end
    @(negedge clkCPU);
    src_addr = 32'h1FC00800; dst_addr = 32'h00008000; word_cnt = CNT_W'(5); start = 1'b1;
    @(posedge clkCPU); #1;
    start = 1'b0; cyc++;
    wait_done(cyc, cyc, bcyc);
    chk("restart_done_cycle", 32'(cyc), 10);
    chk("restart_nreads", 32'(ra_log.size() - ra_base), 2);
    if (ra_log.size() - ra_base >= 2) begin
      chk("restart_raddr1", ra_log[ra_base + 1], 32'h1FC00304);
      chk("restart_waddr1", wa_log[wa_base + 1], 32'h00007004);
      chk("restart_wdata1", wd_log[wd_base + 1], 32'hA5A50001);
    end
    repeat (4) @(posedge clkCPU);
    #1;
    chk("restart_no_second_job", 32'(busy), 0);

    // reset during a stalled read data phase
    mark_bases();
    stall_rd = 1; stall_cyc = 5;
    @(negedge clkCPU);
    src_addr = 32'h1FC00300; dst_addr = 32'h00009000; word_cnt = CNT_W'(1); start = 1'b1;
    @(posedge clkCPU); #1;
    start = 1'b0;
    @(posedge clkCPU); #1;
    chk("pre_rst_in_rd_d", 32'(busy && HTRANS == 2'b00 && !HREADY), 1);
    @(negedge clkCPU) globlRst = 1'b1;
    @(posedge clkCPU); #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_htrans", 32'(HTRANS), 0);
    chk("midrst_haddr", HADDR, 0);
    chk("midrst_hwdata", HWDATA, 0);
    @(negedge clkCPU) globlRst = 1'b0;
    stall_rd = 0;
    pulses = 0;
    repeat (10) begin @(posedge clkCPU); #1; if (done || busy) pulses++; end
    chk("midrst_no_done", 32'(pulses), 0);

    chk("protocol_violations", 32'(viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_sector_dma.md
Name: sd_sector_dma

Overview:
AHB-Lite master that copies a block of 32-bit words between two bus addresses, one word at a time (read then write). It drives the CPU-side bus of the SD wrapper, which decodes the SD data buffer at 0x1FC00xxx and control at 0x1FC01xxx. It moves SD sectors between that buffer window and system RAM without CPU load/store loops. Completion raises an interrupt-style pulse.

Parameters:
CNT_W, 11, width of the word count (max 1024 words = full 4 KiB buffer window)
ADDR_INC, 4, byte increment per word

Ports:
clkCPU  in  1  system clock; all logic on its rising edge
globlRst  in  1  synchronous reset, active-high
start  in  1  one-cycle request; sampled only in IDLE
src_addr  in  32  source byte address; bits [1:0] ignored (forced 0)
dst_addr  in  32  destination byte address; bits [1:0] ignored
word_cnt  in  CNT_W  number of words to copy
busy  out  1  high from cycle after accepted start until DONE
done  out  1  one-cycle pulse at end of job (success or error)
err  out  1  sticky error flag; cleared on next accepted start
HADDR  out  32  AHB address
HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
HBURST  out  3  constant SINGLE (3'b000)
HSIZE  out  3  constant word (3'b010)
HWRITE  out  1  1 in write address phase
HWDATA  out  32  write data, valid in write data phase
HRDATA  in  32  read data
HREADY  in  1  transfer-complete / stall
HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset values: busy=0, done=0, err=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0; state IDLE; internal counters 0.
- Reset mid-transfer: state machine aborts; reset values appear on the cycle after the reset edge; no done pulse.
- States: IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
- IDLE: on start, latch src/dst with [1:0]=0, latch cnt, clear err. If cnt==0, go to FIN. Otherwise go to RD_A. start in any other state is ignored.
- RD_A: HTRANS=NONSEQ, HADDR=src, HWRITE=0. The address phase completes on an edge with HREADY=1, then go to RD_D.
- RD_D: HTRANS=IDLE. On an edge with HREADY=1: capture HRDATA into the data register. If HRESP=1, set err and go to FIN; otherwise go to WR_A. With HREADY=0, hold.
- WR_A: HTRANS=NONSEQ, HADDR=dst, HWRITE=1. On HREADY=1, go to WR_D.
- WR_D: HTRANS=IDLE, HWDATA=captured word, held stable until HREADY=1. On that edge:
  - If HRESP=1, set err and go to FIN.
  - Else src+=ADDR_INC, dst+=ADDR_INC (32-bit wrap), cnt-=1. If the new cnt is 0, go to FIN; else go to RD_A.
- FIN: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Latency with zero wait states: 4 cycles per word; job = 4*N + 2 cycles from the start edge to the done pulse.
- No pipelining of address and data phases across words. HTRANS is never NONSEQ in two consecutive cycles after the current phase completes.
- Write data is byte-complete (word writes only), so the slave asserts all four byte enables.

Decomposition:
- Shared package/header: HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE word encodings (reuse the existing AHB constants header), HRESP_OKAY/ERROR, and the state encoding.
- No sub-module needed. A single FSM plus a datapath of two address counters, a word counter, and a data register.

Test Plan:
1. Zero-wait slave model; src=0x1FC00000, dst=0x00001000, cnt=4, buffer preloaded with 0x11111111..0x44444444 -> reads at 0x1FC00000/04/08/0C, writes of the same data at 0x1000/04/08/0C in order, done pulse 18 cycles after start, err=0.
2. cnt=0 -> done pulses 2 cycles after start; HTRANS stays IDLE throughout; busy high for 1 cycle.
3. HREADY held low 3 cycles in second RD_D, cnt=2 -> HRDATA captured only on the HREADY=1 edge, HTRANS=IDLE during stall, done at 10+3 cycles.
4. HRESP=ERROR on the second write, cnt=4 -> err=1, done pulse, only 2 reads and 2 write address phases issued, HTRANS IDLE afterwards; next start clears err.
5. start reasserted while busy with different addresses -> ignored, original transfer completes unchanged. Then globlRst asserted mid-RD_D -> all outputs at reset values the next cycle, no done pulse.
6. src=0x1FC00003, dst=0x00002002 -> first transfers use 0x1FC00000 and 0x00002000; src=0xFFFFFFFC, cnt=2 -> second read at 0x00000000 (wrap).
